// File: rtl/game_pkg.sv
// Shared constants, ASCII codes and FSM states for the board frame serializer.
// Optional feature macro: CLEAR_SCREEN_EN (prefixes each frame with ESC[2J ESC[H).
package game_pkg;

  localparam int TILE_W  = 20;
  localparam int SCORE_W = 21;
  localparam int DIGITS  = 7;
  localparam int N_TILES = 16;
  localparam int CONV_W  = (TILE_W > SCORE_W) ? TILE_W : SCORE_W;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] ZERO  = 8'h30;

`ifdef CLEAR_SCREEN_EN
  localparam int PREFIX_LEN = 7;
`else
  localparam int PREFIX_LEN = 0;
`endif

  localparam int FRAME_LEN = PREFIX_LEN + N_TILES * DIGITS + (N_TILES / 4) * 2
                           + 7 + DIGITS + 2;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    EMIT,
    ACK,
    DRAIN,
    FIN
  } state_t;

  // Literal text placed ahead of a field: "Score: " before the score,
  // the clear-screen escape sequence before tile 0.
  function automatic logic [7:0] lead_char(input logic is_score, input logic [2:0] idx);
    logic [7:0] c;
    c = SPACE;
    if (is_score) begin
      case (idx)
        3'd0:    c = 8'h53;
        3'd1:    c = 8'h63;
        3'd2:    c = 8'h6F;
        3'd3:    c = 8'h72;
        3'd4:    c = 8'h65;
        3'd5:    c = 8'h3A;
        default: c = SPACE;
      endcase
    end else begin
      case (idx)
        3'd0:    c = ESC;
        3'd1:    c = 8'h5B;
        3'd2:    c = 8'h32;
        3'd3:    c = 8'h4A;
        3'd4:    c = ESC;
        3'd5:    c = 8'h5B;
        default: c = 8'h48;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/board_frame_serializer_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// The BCD result is held after valid pulses until the next load.
module bin2bcd
  import game_pkg::*;
#(
  parameter int BIN_W    = CONV_W,
  parameter int N_DIGITS = DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  valid,
  output logic [N_DIGITS*4-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]      shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [N_DIGITS*4-1:0] adj;

  // Add 3 to every BCD digit that is 5 or more before the next shift.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // Shift one binary bit into the adjusted BCD register per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else if (load) begin
      shift_q <= bin;
      cnt_q   <= CNT_W'(BIN_W);
      bcd     <= '0;
      busy    <= 1'b1;
      valid   <= 1'b0;
    end else if (busy) begin
      bcd     <= {adj[N_DIGITS*4-2:0], shift_q[BIN_W-1]};
      shift_q <= shift_q << 1;
      cnt_q   <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/board_frame_serializer.sv
// Snapshots the 4x4 board and score and streams them as a decimal ASCII text
// frame to a UART through a strobe/busy handshake.
// Optional feature macro: CLEAR_SCREEN_EN (adds the clear-screen prefix).
module board_frame_serializer
  import game_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [16*TILE_W-1:0]    board,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    start,
  input  logic                    tx_busy,
  output logic [7:0]              tx_data,
  output logic                    tx_stb,
  output logic                    busy,
  output logic                    done
);

  state_t state, state_next;

  logic [TILE_W-1:0]   snap_tiles [N_TILES];
  logic [SCORE_W-1:0]  snap_score;
  logic [4:0]          item_idx;
  logic [4:0]          char_pos;
  logic [1:0]          ack_cnt;
  logic                cvt_pending;

  logic                capture, cvt_load, emit, ack_step, next_char, next_item;
  logic                is_score;
  logic [4:0]          lead_len, trail_len, last_pos;
  logic [4:0]          field_pos, digit_idx;
  logic [DIGITS*4-1:0] shifted;
  logic [7:0]          cur_char;
  logic [CONV_W-1:0]   cvt_bin;
  logic                cvt_busy, cvt_valid;
  logic [DIGITS*4-1:0] cvt_bcd;

  bin2bcd #(
    .BIN_W   (CONV_W),
    .N_DIGITS(DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .load (cvt_load),
    .bin  (cvt_bin),
    .busy (cvt_busy),
    .valid(cvt_valid),
    .bcd  (cvt_bcd)
  );

  // Each item is an optional literal lead, the numeric field, then an optional CR LF.
  always_comb begin
    is_score  = (item_idx == 5'(N_TILES));
    lead_len  = is_score ? 5'd7 : ((item_idx == 5'd0) ? 5'(PREFIX_LEN) : 5'd0);
    trail_len = (is_score || item_idx[1:0] == 2'd3) ? 5'd2 : 5'd0;
    last_pos  = lead_len + 5'(DIGITS) + trail_len - 5'd1;
    cvt_bin   = is_score ? CONV_W'(snap_score) : CONV_W'(snap_tiles[item_idx[3:0]]);
  end

  // Character at the current position, with leading zeros blanked to spaces.
  always_comb begin
    cur_char  = SPACE;
    field_pos = char_pos - lead_len;
    digit_idx = 5'(DIGITS - 1) - field_pos;
    shifted   = cvt_bcd >> {digit_idx, 2'b00};
    if (char_pos < lead_len) begin
      cur_char = lead_char(is_score, char_pos[2:0]);
    end else if (field_pos < 5'(DIGITS)) begin
      if (field_pos == 5'(DIGITS - 1)) begin
        if (cvt_bcd == '0) cur_char = is_score ? ZERO : DOT;
        else               cur_char = ZERO + {4'h0, shifted[3:0]};
      end else if (shifted != '0) begin
        cur_char = ZERO + {4'h0, shifted[3:0]};
      end
    end else if (field_pos == 5'(DIGITS)) begin
      cur_char = CR;
    end else begin
      cur_char = LF;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    cvt_load   = 1'b0;
    emit       = 1'b0;
    ack_step   = 1'b0;
    next_char  = 1'b0;
    next_item  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        cvt_load = !cvt_pending && !cvt_busy;
        if (cvt_valid) state_next = EMIT;
      end
      EMIT: begin
        if (!tx_busy) begin
          emit       = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (tx_busy || ack_cnt == 2'd2) state_next = DRAIN;
        else                            ack_step   = 1'b1;
      end
      DRAIN: begin
        if (!tx_busy) begin
          if (char_pos != last_pos) begin
            next_char  = 1'b1;
            state_next = EMIT;
          end else if (is_score) begin
            state_next = FIN;
          end else begin
            next_item  = 1'b1;
            state_next = CONV;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot, position counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TILES; i++) snap_tiles[i] <= '0;
      snap_score  <= '0;
      item_idx    <= '0;
      char_pos    <= '0;
      ack_cnt     <= '0;
      cvt_pending <= 1'b0;
      tx_data     <= '0;
      tx_stb      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      tx_stb <= emit;
      done   <= (state_next == FIN);
      busy   <= (state_next == CONV) || (state_next == EMIT) ||
                (state_next == ACK)  || (state_next == DRAIN);
      if (capture) begin
        for (int i = 0; i < N_TILES; i++) snap_tiles[i] <= board[i*TILE_W +: TILE_W];
        snap_score <= score;
        item_idx   <= '0;
        char_pos   <= '0;
      end
      if (cvt_load)       cvt_pending <= 1'b1;
      else if (cvt_valid) cvt_pending <= 1'b0;
      if (emit) begin
        tx_data <= cur_char;
        ack_cnt <= '0;
      end
      if (ack_step)  ack_cnt  <= ack_cnt + 2'd1;
      if (next_char) char_pos <= char_pos + 5'd1;
      if (next_item) begin
        item_idx <= item_idx + 5'd1;
        char_pos <= '0;
      end
    end
  end

endmodule

// File: tb/tb_board_frame_serializer.sv
// Self-checking bench for board_frame_serializer: random boards against a
// text-level frame model, with a randomised UART busy responder.
// Honours CLEAR_SCREEN_EN to expect the clear-screen prefix.
module tb_board_frame_serializer;

  localparam int TW = 20;
  localparam int SW = 21;
  localparam int NT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NT*TW-1:0] board = '0;
  logic [SW-1:0]    score = '0;
  logic             start = 1'b0;
  logic             tx_busy = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_stb;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  byte unsigned cap_q[$];
  int done_cnt = 0;
  int stb_busy_viol = 0;
  int long_char = -1;
  int bcnt = 0;
  int pend = 0;
  int blen = 0;

  board_frame_serializer dut (
    .clk    (clk),
    .rst    (rst),
    .board  (board),
    .score  (score),
    .start  (start),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_stb (tx_stb),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART responder: captures each strobe, raises busy 0-1 cycles later for a
  // random time, sometimes never raises it at all.
  always @(negedge clk) begin
    if (!rst) begin
      bcnt = 0;
      pend = 0;
      tx_busy = 1'b0;
    end else begin
      if (bcnt > 0) bcnt--;
      if (pend > 0) begin
        pend--;
        if (pend == 0) bcnt = blen;
      end
      if (done) done_cnt++;
      if (tx_stb) begin
        if (tx_busy) stb_busy_viol++;
        cap_q.push_back(tx_data);
        if (cap_q.size() - 1 == long_char) begin
          blen = 500;
          pend = 0;
          bcnt = 500;
        end else if ($urandom_range(0, 7) != 0) begin
          blen = $urandom_range(1, 10);
          pend = $urandom_range(0, 1);
          if (pend == 0) bcnt = blen;
        end
      end
      tx_busy = (bcnt > 0);
    end
  end

  function automatic void push_field(input longint unsigned v, input bit is_score);
    byte unsigned f[7];
    longint unsigned n;
    n = v;
    for (int k = 0; k < 7; k++) f[k] = 8'h20;
    if (v == 0) begin
      f[6] = is_score ? 8'h30 : 8'h2E;
    end else begin
      for (int k = 6; k >= 0; k--) begin
        if (n > 0) begin
          f[k] = 8'(48 + n % 10);
          n = n / 10;
        end
      end
    end
    for (int k = 0; k < 7; k++) exp_q.push_back(f[k]);
  endfunction

  function automatic void build_expected(input logic [NT*TW-1:0] b, input logic [SW-1:0] s);
    string lit;
    lit = "Score: ";
    exp_q.delete();
`ifdef CLEAR_SCREEN_EN
    exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h32);
    exp_q.push_back(8'h4A); exp_q.push_back(8'h1B); exp_q.push_back(8'h5B);
    exp_q.push_back(8'h48);
`endif
    for (int i = 0; i < NT; i++) begin
      push_field(longint'(b[TW*i +: TW]), 1'b0);
      if (i % 4 == 3) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
    for (int i = 0; i < lit.len(); i++) exp_q.push_back(lit[i]);
    push_field(longint'(s), 1'b1);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic logic [NT*TW-1:0] random_board();
    logic [NT*TW-1:0] b;
    logic [31:0] v;
    int unsigned w;
    b = '0;
    for (int i = 0; i < NT; i++) begin
      w = $urandom_range(1, TW);
      v = $urandom;
      v = v & ((32'd1 << w) - 32'd1);
      if ($urandom_range(0, 3) == 0) v = '0;
      b[TW*i +: TW] = v[TW-1:0];
    end
    return b;
  endfunction

  // Runs one frame; toggle wiggles start mid-frame and on the done cycle,
  // scramble changes board/score inputs while the frame is in flight.
  task automatic apply_stimulus(input string name, input logic [NT*TW-1:0] b,
                                input logic [SW-1:0] s, input bit toggle, input bit scramble);
    int cyc;
    bit seen;
    logic [31:0] got;
    logic [31:0] rnd;
    build_expected(b, s);
    cap_q.delete();
    done_cnt = 0;
    stb_busy_viol = 0;
    @(negedge clk);
    board = b;
    score = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (scramble) begin
        board = random_board();
        rnd = $urandom;
        score = rnd[SW-1:0];
      end
      if (done) begin
        seen = 1'b1;
        start = toggle;
      end else if (toggle) begin
        start = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check_output({name, ".done_seen"}, 32'(seen), 32'd1);
    check_output({name, ".done_count"}, done_cnt, 1);
    check_output({name, ".strobe_count"}, cap_q.size(), exp_q.size());
    check_output({name, ".busy_after"}, 32'(busy), 32'd0);
    check_output({name, ".stb_while_busy"}, stb_busy_viol, 0);
    check_output({name, ".tx_data_hold"}, 32'(tx_data), 32'(exp_q[exp_q.size()-1]));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF;
      check_output($sformatf("%s.char%0d", name, i), got, 32'(exp_q[i]));
    end
  endtask

  task automatic reset_mid_frame();
    int cyc;
    cap_q.delete();
    done_cnt = 0;
    @(negedge clk);
    board = random_board();
    score = 21'd12345;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cap_q.size() < 50 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_output("rst.reached_50", 32'(cap_q.size() >= 50), 32'd1);
    rst = 1'b0;
    #1;
    check_output("rst.tx_data", 32'(tx_data), 32'd0);
    check_output("rst.tx_stb", 32'(tx_stb), 32'd0);
    check_output("rst.busy", 32'(busy), 32'd0);
    check_output("rst.done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check_output("rst.no_done", done_cnt, 0);
    check_output("rst.idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [NT*TW-1:0] b;
    logic [31:0] rnd;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset.tx_data", 32'(tx_data), 32'd0);
    check_output("reset.tx_stb", 32'(tx_stb), 32'd0);
    check_output("reset.busy", 32'(busy), 32'd0);
    check_output("reset.done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    apply_stimulus("empty", '0, '0, 1'b0, 1'b0);

    b = '0;
    b[0 +: TW] = 20'd2048;
    b[15*TW +: TW] = 20'd2;
    apply_stimulus("mixed", b, 21'd1024, 1'b0, 1'b0);

    b = '0;
    for (int i = 0; i < NT; i++) b[TW*i +: TW] = 20'd1048575;
    apply_stimulus("max", b, 21'd2097151, 1'b0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      rnd = $urandom;
      apply_stimulus($sformatf("rand%0d", r), random_board(), rnd[SW-1:0], 1'b0, 1'b0);
    end

    rnd = $urandom;
    apply_stimulus("scramble", random_board(), rnd[SW-1:0], 1'b0, 1'b1);

    rnd = $urandom;
    apply_stimulus("toggle", random_board(), rnd[SW-1:0], 1'b1, 1'b0);

    reset_mid_frame();
    rnd = $urandom;
    apply_stimulus("after_rst", random_board(), rnd[SW-1:0], 1'b0, 1'b0);

    long_char = 20;
    rnd = $urandom;
    apply_stimulus("stall", random_board(), rnd[SW-1:0], 1'b0, 1'b0);
    long_char = -1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_frame_serializer.md
Name: board_frame_serializer

Overview:
- Downstream of the game controller, upstream of the UART transmitter.
- On a start request, snapshots the 4x4 board and score, converts each value to decimal ASCII, and streams one text frame, one character at a time, into the UART via a strobe/busy handshake.
- Frame layout:
  - 4 rows, each holding 4 fields of 7 characters, ended by CR LF.
  - Then the string "Score: ", a 7-character score field, and CR LF.
  - Base frame length is 136 characters.

Parameters:
- TILE_W, 20, bits per tile value; board width is 16*TILE_W.
- SCORE_W, 21, score width in bits.
- DIGITS, 7, decimal field width; must hold 2^max(TILE_W,SCORE_W)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- board  in  16*TILE_W  tile i = board[TILE_W*i +: TILE_W]; i=0 is top-left, row-major.
- score  in  SCORE_W  unsigned score.
- start  in  1  frame request, level or pulse.
- tx_busy  in  1  UART busy; high while a character is being shifted out.
- tx_data  out  8  ASCII character; valid while tx_stb is high.
- tx_stb  out  1  one-cycle character strobe.
- busy  out  1  high from frame acceptance until done.
- done  out  1  one-cycle pulse after the last character is accepted.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; tx_data=0, tx_stb=0, busy=0, done=0; snapshot registers cleared.
- IDLE:
  - When start=1, capture board and score into snapshot registers.
  - Set busy=1 on the next cycle and go to CONV.
  - start is ignored while busy=1; no queueing.
- CONV:
  - The current item (tile 0..15, then score) is loaded into the bin2bcd sub-module.
  - Conversion is sequential double-dabble, one bit per cycle, with fixed latency max(TILE_W,SCORE_W) cycles.
  - Go to EMIT.
- Field formatting:
  - Leading zeros are printed as spaces (0x20).
  - A tile equal to 0 prints as 6 spaces followed by '.' (0x2E).
  - A score of 0 prints as 6 spaces followed by '0'.
  - Digits are 0x30 plus the BCD digit.
- Literal characters: CR LF (0x0D 0x0A) after every 4th tile; "Score: " before the score field; CR LF at frame end.
- EMIT:
  - Waits until tx_busy=0, then drives tx_data and asserts tx_stb for exactly one cycle.
  - Go to ACK.
- ACK:
  - Waits for tx_busy=1. The UART may raise busy up to 2 cycles after the strobe.
  - If busy is still not seen after 2 cycles, treat the character as accepted.
  - Then go to DRAIN.
- DRAIN:
  - Waits for tx_busy=0.
  - Then advance the character index: the next field character goes to EMIT; a new item goes to CONV; after the last character go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE. A start on the done cycle is ignored.
- Exactly one tx_stb is issued per character, and the total strobe count equals the frame length.
- tx_data holds its value until the next strobe.
- Reset mid-frame: immediate abort with no done pulse. The next frame starts clean from tile 0.
- Input changes on board or score during a frame have no effect, because the snapshot is used.
- tx_busy stuck high: the block waits indefinitely. There is no timeout in DRAIN.

Optional Feature:
- Macro CLEAR_SCREEN_EN.
- When defined, every frame is prefixed with ESC "[2J" ESC "[H" (0x1B 0x5B 0x32 0x4A 0x1B 0x5B 0x48). Frame length becomes 143 characters.
- When undefined, no prefix is sent and the frame is 136 characters.

Decomposition:
- Shared package game_pkg holds:
  - TILE_W, SCORE_W, DIGITS, and N_TILES=16;
  - ASCII constants (SPACE, DOT, CR, LF, ESC, ZERO);
  - the state enum (IDLE, CONV, EMIT, ACK, DRAIN, FIN);
  - the FRAME_LEN constant.
- Sub-module bin2bcd: sequential double-dabble with load/busy/valid signals, a binary input of max(TILE_W,SCORE_W) bits, and DIGITS*4 bits of BCD output.

Test Plan:
- Empty board with score 0, start pulse, UART model raising busy 1 cycle after each strobe for 10 cycles:
  - 136 strobes.
  - Each row reads "      ." four times followed by CR LF.
  - The last line reads "Score:       0" CR LF.
  - One done pulse, with busy low afterwards.
- Tile0=2048, tile15=2, score=1024:
  - Row 0 starts "   2048".
  - Row 3 ends "      2" CR LF.
  - Score field reads "   1024".
- Maximum values, with all tiles 1048575 and score 2097151: every field reads "1048575" and the score field reads "2097151". No wrap.
- start toggled repeatedly mid-frame, plus start asserted on the done cycle: exactly 136 strobes and one done; no second frame.
- rst driven low after 50 strobes: outputs are zero asynchronously and there is no done pulse. A following start produces a full correct frame.
- CLEAR_SCREEN_EN defined, and tx_busy held high 500 cycles before one character: first 7 characters are the escape sequence, total 143 strobes, and no strobe is issued while tx_busy=1.
